// File: rtl/frame_mem_sched_pkg.sv
// Shared types and geometry for the frame memory scheduler.
// Maps a panel pixel to its {bank, address} in the split frame memory.
package frame_mem_pkg;

    localparam int PANEL_W = 64;
    localparam int HALF_H  = 32;
    localparam int ADDR_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_DRAW,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
    } pix_loc_t;

    // Upper panel half lives in bank 0, lower half in bank 1.
    function automatic pix_loc_t pix_map(input logic [7:0] x,
                                         input logic [7:0] y);
        pix_loc_t   r;
        logic [7:0] row;
        r.bank = (y >= 8'(HALF_H));
        row    = r.bank ? (y - 8'(HALF_H)) : y;
        r.addr = ADDR_W'(row) * ADDR_W'(PANEL_W) + ADDR_W'(x);
        return r;
    endfunction

endpackage

// File: rtl/frame_mem_sched_walker.sv
// Row-major walk over the cursor square from a base position.
// Produces the memory location, clip flag and last-pixel flag.
module cursor_pixel_walker
    import frame_mem_pkg::*;
#(
    parameter int CUR_SIZE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        base_x_i,
    input  logic [6:0]        base_y_i,
    input  logic              adv_i,
    output logic              clip_o,
    output logic              last_o,
    output logic              bank_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int CW = (CUR_SIZE > 1) ? $clog2(CUR_SIZE) : 1;

    logic [CW-1:0] dx_q, dx_d;
    logic [CW-1:0] dy_q, dy_d;
    logic          last_x;
    logic [7:0]    x, y;
    pix_loc_t      loc;

    assign last_x = (dx_q == CW'(CUR_SIZE - 1));
    assign last_o = last_x && (dy_q == CW'(CUR_SIZE - 1));

    // Step dx, wrap into dy; wrap both after the last pixel.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (adv_i) begin
            if (last_x) begin
                dx_d = '0;
                dy_d = last_o ? '0 : dy_q + CW'(1);
            end else begin
                dx_d = dx_q + CW'(1);
            end
        end
    end

    // Walk counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign x      = {1'b0, base_x_i} + 8'(dx_q);
    assign y      = {1'b0, base_y_i} + 8'(dy_q);
    assign clip_o = (x >= 8'(PANEL_W)) || (y >= 8'(2 * HALF_H));
    assign loc    = pix_map(x, y);
    assign bank_o = loc.bank;
    assign addr_o = loc.addr;

endmodule

// File: rtl/frame_mem_sched.sv
// Frame memory port scheduler: display reads vs. cursor restore/draw.
// FRAME_MEM_CURSOR_RESTORE_EN enables restoring the old cursor area.
module frame_mem_sched
    import frame_mem_pkg::*;
#(
    parameter int          CUR_SIZE   = 2,
    parameter logic [11:0] CUR_COLOR  = 12'hFFF,
    parameter int          STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [23:0]       disp_data,
    input  logic              cur_req,
    input  logic [6:0]        cur_x,
    input  logic [6:0]        cur_y,
    output logic              cur_busy,
    output logic              cur_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr0,
    output logic              mem_wr1,
    output logic [11:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    input  logic [11:0]       mem_b_rdata0,
    input  logic [11:0]       mem_b_rdata1
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e            state_q, state_d;
    logic [6:0]        new_x_q, new_x_d;
    logic [6:0]        new_y_q, new_y_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic              disp_valid_q;

    logic              walk;
    logic              force_cur;
    logic              slot;
    logic              port_cur;
    logic [6:0]        base_x, base_y;
    logic              w_clip, w_last, w_bank;
    logic [ADDR_W-1:0] w_addr;

`ifdef FRAME_MEM_CURSOR_RESTORE_EN
    logic [6:0] old_x_q, old_y_q;
    logic       old_valid_q;

    // Old position becomes the restore source once a move finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            old_x_q     <= '0;
            old_y_q     <= '0;
            old_valid_q <= 1'b0;
        end else if (state_q == ST_DONE) begin
            old_x_q     <= new_x_q;
            old_y_q     <= new_y_q;
            old_valid_q <= 1'b1;
        end
    end

    assign base_x = (state_q == ST_RESTORE) ? old_x_q : new_x_q;
    assign base_y = (state_q == ST_RESTORE) ? old_y_q : new_y_q;
`else
    logic unused_bk;
    assign unused_bk = ^{mem_b_rdata0, mem_b_rdata1};
    assign base_x    = new_x_q;
    assign base_y    = new_y_q;
`endif

    assign walk      = (state_q == ST_RESTORE) || (state_q == ST_DRAW);
    assign force_cur = (stall_q == SW'(STARVE_MAX));
    assign disp_gnt  = disp_req && !force_cur;
    assign slot      = walk && (w_clip || !disp_gnt);
    assign port_cur  = walk && !w_clip && !disp_gnt;

    cursor_pixel_walker #(
        .CUR_SIZE (CUR_SIZE)
    ) u_walker (
        .clk      (clk),
        .rst      (rst),
        .base_x_i (base_x),
        .base_y_i (base_y),
        .adv_i    (slot),
        .clip_o   (w_clip),
        .last_o   (w_last),
        .bank_o   (w_bank),
        .addr_o   (w_addr)
    );

    // Move sequencing and new-position capture.
    always_comb begin
        state_d = state_q;
        new_x_d = new_x_q;
        new_y_d = new_y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cur_req) begin
                    new_x_d = cur_x;
                    new_y_d = cur_y;
`ifdef FRAME_MEM_CURSOR_RESTORE_EN
                    state_d = old_valid_q ? ST_RESTORE : ST_DRAW;
`else
                    state_d = ST_DRAW;
`endif
                end
            end
            ST_RESTORE: if (slot && w_last) state_d = ST_DRAW;
            ST_DRAW:    if (slot && w_last) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Count cycles the cursor loses to the display; any slot clears it.
    always_comb begin
        stall_d = stall_q;
        if (walk) begin
            stall_d = slot ? '0 : stall_q + SW'(1);
        end
    end

    // State, position and stall registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            new_x_q      <= '0;
            new_y_q      <= '0;
            stall_q      <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            stall_q      <= stall_d;
            disp_valid_q <= disp_gnt;
        end
    end

    // Memory port mux: display read, cursor write, or parked.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr0   = 1'b0;
        mem_wr1   = 1'b0;
        mem_wdata = '0;
        if (disp_gnt) begin
            mem_addr = disp_addr;
            mem_rd   = 1'b1;
        end else if (port_cur) begin
            mem_addr  = w_addr;
            mem_wr0   = !w_bank;
            mem_wr1   = w_bank;
            mem_wdata = CUR_COLOR;
`ifdef FRAME_MEM_CURSOR_RESTORE_EN
            if (state_q == ST_RESTORE) begin
                mem_wdata = w_bank ? mem_b_rdata1 : mem_b_rdata0;
            end
`endif
        end
    end

    assign cur_busy   = (state_q != ST_IDLE);
    assign cur_done   = (state_q == ST_DONE);
    assign disp_valid = disp_valid_q;
    assign disp_data  = mem_rdata;

endmodule

// File: tb/tb_frame_mem_sched.sv
// Directed bench for frame_mem_sched with a frame/backup memory model.
// Expectations follow FRAME_MEM_CURSOR_RESTORE_EN when it is defined.
module tb_frame_mem_sched;

`ifdef FRAME_MEM_CURSOR_RESTORE_EN
    localparam bit RESTORE_EN = 1'b1;
`else
    localparam bit RESTORE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_gnt;
    logic        disp_valid;
    logic [23:0] disp_data;
    logic        cur_req;
    logic [6:0]  cur_x;
    logic [6:0]  cur_y;
    logic        cur_busy;
    logic        cur_done;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr0;
    logic        mem_wr1;
    logic [11:0] mem_wdata;
    logic [23:0] mem_rdata = '0;
    logic [11:0] mem_b_rdata0;
    logic [11:0] mem_b_rdata1;

    logic [11:0] MEM0 [0:2047];
    logic [11:0] MEM1 [0:2047];
    logic [11:0] B0 [0:2047];
    logic [11:0] B1 [0:2047];
    logic        inited = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [29:0] obs;

    int mv_x [3] = '{10, 10, 63};
    int mv_y [3] = '{3, 40, 63};
    int pa [3][4] = '{'{202, 203, 266, 267},
                      '{522, 523, 586, 587},
                      '{2047, 0, 0, 0}};
    bit pb [3][4] = '{'{0, 0, 0, 0}, '{1, 1, 1, 1}, '{1, 0, 0, 0}};
    bit pv [3][4] = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}, '{1, 0, 0, 0}};

    always #5 clk = ~clk;

    frame_mem_sched dut (
        .clk          (clk),
        .rst          (rst),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_gnt     (disp_gnt),
        .disp_valid   (disp_valid),
        .disp_data    (disp_data),
        .cur_req      (cur_req),
        .cur_x        (cur_x),
        .cur_y        (cur_y),
        .cur_busy     (cur_busy),
        .cur_done     (cur_done),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr0      (mem_wr0),
        .mem_wr1      (mem_wr1),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_b_rdata0 (mem_b_rdata0),
        .mem_b_rdata1 (mem_b_rdata1)
    );

    assign obs = {disp_gnt, cur_busy, cur_done, mem_rd,
                  mem_wr0, mem_wr1, mem_addr, mem_wdata};

    assign mem_b_rdata0 = B0[mem_addr];
    assign mem_b_rdata1 = B1[mem_addr];

    always @(posedge clk) begin
        if (!inited) begin
            for (int i = 0; i < 2048; i++) begin
                MEM0[i] <= 12'h100 + 12'(i);
                MEM1[i] <= 12'h200 + 12'(i);
            end
            inited <= 1'b1;
        end else begin
            if (mem_wr0) MEM0[mem_addr] <= mem_wdata;
            if (mem_wr1) MEM1[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_rd) mem_rdata <= {MEM0[mem_addr], MEM1[mem_addr]};
    end

    function automatic logic [29:0] ev(input logic g, input logic b,
                                       input logic d, input logic r,
                                       input logic w0, input logic w1,
                                       input logic [11:0] a,
                                       input logic [11:0] dt);
        return {g, b, d, r, w0, w1, a, dt};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quick_move(input int x, input int y, output bit ok);
        nxt();
        cur_req = 1'b1;
        cur_x   = 7'(x);
        cur_y   = 7'(y);
        nxt();
        cur_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!cur_busy) begin
                ok = 1'b1;
                break;
            end
            nxt();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) nxt();
        #1;
        n_checks++;
        if ({cur_busy, cur_done, disp_valid, mem_rd, mem_wr0, mem_wr1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {cur_busy, cur_done, disp_valid, mem_rd, mem_wr0, mem_wr1});
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h want 000000", {mem_addr, mem_wdata});
        end
        nxt();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({disp_valid, obs} !== 31'h0) begin
            n_fail++;
            $display("FAIL post_reset: got %h want 0", {disp_valid, obs});
        end
    endtask

    task automatic test_disp_read();
        nxt();
        disp_req  = 1'b1;
        disp_addr = 12'd5;
        #1;
        n_checks++;
        if (obs !== ev(1, 0, 0, 1, 0, 0, 12'd5, 12'h0)) begin
            n_fail++;
            $display("FAIL disp_grant: got %h want %h", obs,
                     ev(1, 0, 0, 1, 0, 0, 12'd5, 12'h0));
        end
        nxt();
        disp_req = 1'b0;
        #1;
        n_checks++;
        if (disp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL disp_valid: got %b want 1", disp_valid);
        end
        n_checks++;
        if (disp_data !== 24'h105205) begin
            n_fail++;
            $display("FAIL disp_data: got %h want 105205", disp_data);
        end
        nxt();
        #1;
        n_checks++;
        if (disp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_valid_drop: got %b want 0", disp_valid);
        end
    endtask

    task automatic test_moves();
        logic [29:0] q[$];
        logic [11:0] a;
        for (int m = 0; m < 3; m++) begin
            q.delete();
            if (RESTORE_EN && m > 0) begin
                for (int s = 0; s < 4; s++) begin
                    a = 12'(pa[m-1][s]);
                    if (pv[m-1][s])
                        q.push_back(ev(0, 1, 0, 0, !pb[m-1][s], pb[m-1][s], a,
                                       pb[m-1][s] ? B1[a] : B0[a]));
                    else
                        q.push_back(ev(0, 1, 0, 0, 0, 0, 12'h0, 12'h0));
                end
            end
            for (int s = 0; s < 4; s++) begin
                a = 12'(pa[m][s]);
                if (pv[m][s])
                    q.push_back(ev(0, 1, 0, 0, !pb[m][s], pb[m][s], a, 12'hFFF));
                else
                    q.push_back(ev(0, 1, 0, 0, 0, 0, 12'h0, 12'h0));
            end
            q.push_back(ev(0, 1, 1, 0, 0, 0, 12'h0, 12'h0));
            q.push_back(ev(0, 0, 0, 0, 0, 0, 12'h0, 12'h0));
            nxt();
            cur_req = 1'b1;
            cur_x   = 7'(mv_x[m]);
            cur_y   = 7'(mv_y[m]);
            #1;
            n_checks++;
            if (obs !== 30'h0) begin
                n_fail++;
                $display("FAIL move%0d_accept: got %h want 0", m, obs);
            end
            foreach (q[i]) begin
                nxt();
                cur_req = 1'b0;
                #1;
                n_checks++;
                if (obs !== q[i]) begin
                    n_fail++;
                    $display("FAIL move%0d_cyc%0d: got %h want %h",
                             m, i + 1, obs, q[i]);
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic [29:0] q[$];
        int rs [4] = '{340, 341, 404, 405};
        int ds [4] = '{670, 671, 734, 735};
        int nr;
        int nw;
        bit ok;
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        quick_move(20, 5, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_setup_timeout: got busy want idle");
        end
        nr = RESTORE_EN ? 4 : 0;
        q.delete();
        for (int k = 0; k < 5 * (nr + 4); k++) begin
            if (k % 5 != 4)
                q.push_back(ev(1, 1, 0, 1, 0, 0, 12'd7, 12'h0));
            else if (k / 5 < nr)
                q.push_back(ev(0, 1, 0, 0, 1, 0, 12'(rs[k/5]), B0[rs[k/5]]));
            else
                q.push_back(ev(0, 1, 0, 0, 1, 0, 12'(ds[k/5 - nr]), 12'hFFF));
        end
        q.push_back(ev(1, 1, 1, 1, 0, 0, 12'd7, 12'h0));
        q.push_back(ev(1, 0, 0, 1, 0, 0, 12'd7, 12'h0));
        nxt();
        disp_req  = 1'b1;
        disp_addr = 12'd7;
        cur_req   = 1'b1;
        cur_x     = 7'd30;
        cur_y     = 7'd10;
        #1;
        n_checks++;
        if (obs !== ev(1, 0, 0, 1, 0, 0, 12'd7, 12'h0)) begin
            n_fail++;
            $display("FAIL starve_accept: got %h want %h", obs,
                     ev(1, 0, 0, 1, 0, 0, 12'd7, 12'h0));
        end
        nw = 0;
        foreach (q[i]) begin
            nxt();
            cur_req = 1'b0;
            #1;
            if (mem_wr0 || mem_wr1) nw++;
            n_checks++;
            if (obs !== q[i]) begin
                n_fail++;
                $display("FAIL starve_cyc%0d: got %h want %h", i + 1, obs, q[i]);
            end
        end
        n_checks++;
        if (nw !== nr + 4) begin
            n_fail++;
            $display("FAIL starve_writes: got %0d want %0d", nw, nr + 4);
        end
        nxt();
        disp_req = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        int  dstart;
        bit  ok;
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        quick_move(20, 5, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_setup_timeout: got busy want idle");
        end
        dstart = RESTORE_EN ? 5 : 1;
        nxt();
        cur_req = 1'b1;
        cur_x   = 7'd10;
        cur_y   = 7'd3;
        for (int i = 1; i <= dstart; i++) begin
            nxt();
            cur_req = 1'b0;
        end
        nxt();
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== ev(0, 1, 0, 0, 1, 0, 12'd203, 12'hFFF)) begin
            n_fail++;
            $display("FAIL rstmid_draw2: got %h want %h", obs,
                     ev(0, 1, 0, 0, 1, 0, 12'd203, 12'hFFF));
        end
        nxt();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %h want 0", obs);
        end
        cur_req = 1'b1;
        cur_x   = 7'd1;
        cur_y   = 7'd1;
        nxt();
        cur_req = 1'b0;
        #1;
        n_checks++;
        if (obs !== ev(0, 1, 0, 0, 1, 0, 12'd65, 12'hFFF)) begin
            n_fail++;
            $display("FAIL rstmid_no_restore: got %h want %h", obs,
                     ev(0, 1, 0, 0, 1, 0, 12'd65, 12'hFFF));
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (!cur_busy) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_finish_timeout: got busy want idle");
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            B0[i] = 12'hA00 ^ 12'(i);
            B1[i] = 12'h500 ^ 12'(i);
        end
        rst       = 1'b1;
        disp_req  = 1'b0;
        disp_addr = '0;
        cur_req   = 1'b0;
        cur_x     = '0;
        cur_y     = '0;
        test_reset();
        test_disp_read();
        test_moves();
        test_starvation();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
